// File: rtl/mem_bus_master.sv
// Single-outstanding bus master bridging MEM-stage load/store requests onto a
// shared tri-state memory bus with a fixed number of wait states.
module mem_bus_master #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [19:0] ADDR_LIMIT  = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [19:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  inout  wire  [15:0] bus_data,
  output logic [19:0] bus_addr,
  output logic        read,
  output logic        write
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        in_access_s;
  logic        accept_s;
  logic        addr_bad_s;

  assign in_access_s = (state_q == ACCESS);
  assign accept_s    = req_valid && !in_access_s;
  assign addr_bad_s  = (req_addr > ADDR_LIMIT);

  // State and request registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 20'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; RESP accepts like IDLE so back-to-back requests overlap.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept_s) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_write;
          cnt_d   = WS;
          err_d   = addr_bad_s;
          if (addr_bad_s) begin
            state_d = RESP;
            rdata_d = 16'd0;
          end else begin
            state_d = ACCESS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          rdata_d = we_q ? 16'd0 : bus_data;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write strobe only on the final cycle so memory sees a single commit edge.
  assign bus_addr   = in_access_s ? addr_q : 20'd0;
  assign read       = in_access_s && !we_q;
  assign write      = in_access_s && we_q && (cnt_q == 4'd0);
  assign bus_data   = (in_access_s && we_q) ? wdata_q : 16'hzzzz;
  assign req_ready  = !in_access_s;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench: two instances (0 and 3 wait states) each with a small
// bus memory; released bus lines are pulled high so a float reads 16'hFFFF.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  vld;
  logic        we;
  logic [19:0] addr;
  logic [15:0] wd;
  logic [1:0]  rdy, rv, err, rd, wr;
  logic [15:0] rdata [2];
  logic [19:0] baddr [2];
  tri1  [15:0] bd0;
  tri1  [15:0] bd1;
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  logic        pl_we;
  logic [7:0]  pl_a;
  logic [15:0] pl_d;
  int          checks = 0;
  int          errors = 0;
  int          wr1_cnt = 0;
  int          rv1_cnt = 0;

  typedef struct {
    logic        w;
    logic [19:0] a;
    logic [15:0] d;
    logic        e;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t vt [6];

  always #5 clk = ~clk;

  mem_bus_master #(.WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_write(we),
    .req_addr(addr), .req_wdata(wd), .req_ready(rdy[0]), .resp_valid(rv[0]),
    .resp_rdata(rdata[0]), .resp_err(err[0]), .bus_data(bd0),
    .bus_addr(baddr[0]), .read(rd[0]), .write(wr[0])
  );

  mem_bus_master #(.WAIT_STATES(3), .ADDR_LIMIT(20'h003FF)) u3 (
    .clk(clk), .reset(reset), .req_valid(vld[1]), .req_write(we),
    .req_addr(addr), .req_wdata(wd), .req_ready(rdy[1]), .resp_valid(rv[1]),
    .resp_rdata(rdata[1]), .resp_err(err[1]), .bus_data(bd1),
    .bus_addr(baddr[1]), .read(rd[1]), .write(wr[1])
  );

  // Asynchronous-read memories mapped at 0x00000-0x000FF.
  assign bd0 = (rd[0] && baddr[0][19:8] == 12'd0) ? mem0[baddr[0][7:0]] : 16'hzzzz;
  assign bd1 = (rd[1] && baddr[1][19:8] == 12'd0) ? mem1[baddr[1][7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (wr[0] && baddr[0][19:8] == 12'd0) mem0[baddr[0][7:0]] <= bd0;
    else if (pl_we) mem0[pl_a] <= pl_d;
    if (wr[1] && baddr[1][19:8] == 12'd0) mem1[baddr[1][7:0]] <= bd1;
    else if (pl_we) mem1[pl_a] <= pl_d;
    if (wr[1]) wr1_cnt <= wr1_cnt + 1;
    if (rv[1]) rv1_cnt <= rv1_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_a = a; pl_d = d; pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic txn(input int d, input logic w, input logic [19:0] a,
                     input logic [15:0] dat, input logic e,
                     input logic [15:0] exp_rd, input int ws);
    int lat = 0;
    int rc = 0;
    int wc = 0;
    int nr = 0;
    logic [15:0] bus;
    @(negedge clk);
    chk("ready_before", {31'd0, rdy[d]}, 32'd1);
    we = w; addr = a; wd = dat; vld[d] = 1'b1;
    @(posedge clk);
    #1 vld[d] = 1'b0;
    for (int n = 1; n <= 25 && lat == 0; n++) begin
      @(negedge clk);
      bus = (d == 0) ? bd0 : bd1;
      if (rd[d]) rc++;
      if (!rdy[d]) nr++;
      if (rd[d] && wr[d]) chk("rd_wr_excl", 32'd1, 32'd0);
      if (wr[d]) begin
        wc++;
        chk("wr_addr", {12'd0, baddr[d]}, {12'd0, a});
        chk("wr_data", {16'd0, bus}, {16'd0, dat});
      end
      if (rv[d]) begin
        lat = n;
        chk("resp_bus_released", {16'd0, bus}, 32'h0000FFFF);
        chk("resp_addr_zero", {12'd0, baddr[d]}, 32'd0);
        chk("resp_err", {31'd0, err[d]}, {31'd0, e});
        chk("resp_rdata", {16'd0, rdata[d]}, {16'd0, exp_rd});
      end
    end
    chk("latency", lat, e ? 32'd1 : 32'(2 + ws));
    chk("read_cycles", rc, (e || w) ? 32'd0 : 32'(ws + 1));
    chk("write_cycles", wc, (e || !w) ? 32'd0 : 32'd1);
    chk("not_ready_cycles", nr, e ? 32'd0 : 32'(ws + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; vld = 2'b00; we = 1'b0; addr = 20'd0; wd = 16'd0;
    pl_we = 1'b0; pl_a = 8'd0; pl_d = 16'd0;
    preload(8'h05, 16'h0F0F);
    preload(8'h30, 16'h1234);
    preload(8'h20, 16'h5555);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", {31'd0, rdy[i]}, 32'd1);
      chk("rst_resp_valid", {31'd0, rv[i]}, 32'd0);
      chk("rst_resp_err", {31'd0, err[i]}, 32'd0);
      chk("rst_rdata", {16'd0, rdata[i]}, 32'd0);
      chk("rst_bus_addr", {12'd0, baddr[i]}, 32'd0);
      chk("rst_read", {31'd0, rd[i]}, 32'd0);
      chk("rst_write", {31'd0, wr[i]}, 32'd0);
    end
    chk("rst_bus0_z", {16'd0, bd0}, 32'h0000FFFF);
    chk("rst_bus1_z", {16'd0, bd1}, 32'h0000FFFF);

    // Zero-wait-state vectors; 0xFFFFF is legal but unmapped.
    vt[0] = '{1'b1, 20'h00010, 16'hBEEF, 1'b0, 16'h0000};
    vt[1] = '{1'b0, 20'h00010, 16'h0000, 1'b0, 16'hBEEF};
    vt[2] = '{1'b1, 20'h000AB, 16'h1357, 1'b0, 16'h0000};
    vt[3] = '{1'b0, 20'h000AB, 16'h0000, 1'b0, 16'h1357};
    vt[4] = '{1'b0, 20'h00005, 16'h0000, 1'b0, 16'h0F0F};
    vt[5] = '{1'b1, 20'hFFFFF, 16'h4242, 1'b0, 16'h0000};
    for (int i = 0; i < 6; i++)
      txn(0, vt[i].w, vt[i].a, vt[i].d, vt[i].e, vt[i].exp_rd, 0);

    // Three wait states, then an out-of-range load.
    txn(1, 1'b0, 20'h00030, 16'h0000, 1'b0, 16'h1234, 3);
    txn(1, 1'b0, 20'h00400, 16'h0000, 1'b1, 16'h0000, 3);

    // Back-to-back: request held valid, load presented while store runs.
    @(negedge clk);
    we = 1'b1; addr = 20'h000C4; wd = 16'hC0DE; vld[0] = 1'b1;
    @(posedge clk);
    #1 we = 1'b0; wd = 16'h0000;
    @(negedge clk);
    chk("b2b_store_write", {31'd0, wr[0]}, 32'd1);
    chk("b2b_busy", {31'd0, rdy[0]}, 32'd0);
    @(negedge clk);
    chk("b2b_resp1", {31'd0, rv[0]}, 32'd1);
    chk("b2b_ready_in_resp", {31'd0, rdy[0]}, 32'd1);
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    chk("b2b_no_gap_read", {31'd0, rd[0]}, 32'd1);
    chk("b2b_load_addr", {12'd0, baddr[0]}, 32'h000C4);
    chk("b2b_no_resp", {31'd0, rv[0]}, 32'd0);
    @(negedge clk);
    chk("b2b_resp2", {31'd0, rv[0]}, 32'd1);
    chk("b2b_rdata", {16'd0, rdata[0]}, 32'h0000C0DE);

    // Reset during the second ACCESS cycle of a 3-wait-state store.
    @(negedge clk);
    we = 1'b1; addr = 20'h00020; wd = 16'hAAAA; vld[1] = 1'b1;
    @(posedge clk);
    #1 vld[1] = 1'b0;
    @(negedge clk);
    chk("rst_mid_driving", {16'd0, bd1}, 32'h0000AAAA);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_write", {31'd0, wr[1]}, 32'd0);
    chk("rst_mid_bus_z", {16'd0, bd1}, 32'h0000FFFF);
    chk("rst_mid_addr", {12'd0, baddr[1]}, 32'd0);
    chk("rst_mid_ready", {31'd0, rdy[1]}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_mid_no_write", wr1_cnt, 32'd0);
    chk("rst_mid_no_resp", rv1_cnt, 32'd2);
    chk("rst_mid_mem", {16'd0, mem1[8'h20]}, 32'h00005555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
